// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for an 8x8 LED matrix: steps columns with blank/dwell timing and presents
// front-bank row bytes from a double-buffered frame store whose swap is deferred to frame end.
module matrix_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic [2:0] col_sel,
    output logic [7:0] row_data,
    output logic       drive_en,
    output logic       frame_start,
    output logic       swap_pending,
    output logic       swap_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       col_q, col_d;
    logic [7:0]       row_q, row_d;
    logic             drive_q, drive_d;
    logic             fs_q, fs_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             bank_sel_q, bank_sel_d;
    logic [63:0]      bank0_q, bank0_d;
    logic [63:0]      bank1_q, bank1_d;
    logic [63:0]      front_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drive_q    <= 1'b0;
            fs_q       <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            bank_sel_q <= 1'b0;
            bank0_q    <= '0;
            bank1_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drive_q    <= drive_d;
            fs_q       <= fs_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            bank_sel_q <= bank_sel_d;
            bank0_q    <= bank0_d;
            bank1_q    <= bank1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        col_d      = col_q;
        row_d      = row_q;
        drive_d    = drive_q;
        fs_d       = 1'b0;
        pend_d     = pend_q | swap_req;
        done_d     = 1'b0;
        bank_sel_d = bank_sel_q;
        bank0_d    = bank0_q;
        bank1_d    = bank1_q;
        front_c    = bank_sel_q ? bank1_q : bank0_q;

        // Host writes always target the bank that is back before this edge.
        if (wr_en) begin
            if (bank_sel_q) begin
                bank0_d[{wr_addr, 3'b000} +: 8] = wr_data;
            end else begin
                bank1_d[{wr_addr, 3'b000} +: 8] = wr_data;
            end
        end

        case (state_q)
            IDLE: begin
                drive_d = 1'b0;
                if (ena) begin
                    state_d = BLANK;
                    timer_d = '0;
                    col_d   = '0;
                    fs_d    = 1'b1;
                end
            end
            BLANK: begin
                if (!ena) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                    col_d   = '0;
                    timer_d = '0;
                end else if (timer_q == BLANK_LAST) begin
                    row_d   = front_c[{col_q, 3'b000} +: 8];
                    timer_d = '0;
                    drive_d = 1'b1;
                    state_d = DWELL;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DWELL: begin
                if (!ena) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                    col_d   = '0;
                    timer_d = '0;
                end else if (timer_q == DWELL_LAST) begin
                    timer_d = '0;
                    col_d   = col_q + 3'd1;
                    drive_d = 1'b0;
                    state_d = BLANK;
                    // End of column 7 is the frame boundary: the only point a swap may land.
                    if (col_q == 3'd7) begin
                        fs_d = 1'b1;
                        if (pend_q | swap_req) begin
                            bank_sel_d = ~bank_sel_q;
                            pend_d     = 1'b0;
                            done_d     = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                drive_d = 1'b0;
            end
        endcase
    end

    assign col_sel      = col_q;
    assign row_data     = row_q;
    assign drive_en     = drive_q;
    assign frame_start  = fs_q;
    assign swap_pending = pend_q;
    assign swap_done    = done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: per-cycle scan timing checks plus a queue of expected
// (column, row byte) pairs popped on each rising edge of drive_en.
module tb_matrix_scan_ctrl;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int PER   = DW + BL;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [2:0] col_sel;
    logic [7:0] row_data;
    logic       drive_en;
    logic       frame_start;
    logic       swap_pending;
    logic       swap_done;

    typedef struct packed {
        logic [2:0] col;
        logic [7:0] row;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    logic prev_drive = 1'b0;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL),
        .CNT_W       (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .col_sel     (col_sel),
        .row_data    (row_data),
        .drive_en    (drive_en),
        .frame_start (frame_start),
        .swap_pending(swap_pending),
        .swap_done   (swap_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int col, input logic [7:0] row);
        exp_t e;
        e.col = 3'(col);
        e.row = row;
        sb_q.push_back(e);
    endtask

    // One clock; on each new dwell, compare the shown column/byte against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (drive_en === 1'b1 && prev_drive === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_total++;
                n_fail++;
                $error("FAIL sb_underflow: observed dwell on col %0d, expected no dwell", col_sel);
            end else begin
                e = sb_q.pop_front();
                chk("sb_col", 32'(col_sel), 32'(e.col));
                chk($sformatf("sb_row_col%0d", e.col), 32'(row_data), 32'(e.row));
            end
        end
        prev_drive = drive_en;
    endtask

    // Steps frame cycles k0..k1 (k=1 is the frame_start cycle) checking the scan timing.
    task automatic scan(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            step();
            chk($sformatf("drive_en_k%0d", k), 32'(drive_en), 32'(((k - 1) % PER) >= BL));
            chk($sformatf("col_sel_k%0d", k), 32'(col_sel), 32'((k - 1) / PER));
            chk($sformatf("frame_start_k%0d", k), 32'(frame_start), 32'(k == 1));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_col_sel"}, 32'(col_sel), 32'd0);
        chk({tag, "_row_data"}, 32'(row_data), 32'd0);
        chk({tag, "_drive_en"}, 32'(drive_en), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_swap_pending"}, 32'(swap_pending), 32'd0);
        chk({tag, "_swap_done"}, 32'(swap_done), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        step();
        step();
        chk_reset_state("rst");
        rst = 1'b0;

        // Frame A: front bank all zero; 0xA5 written to back must not appear.
        for (int n = 0; n < 8; n++) push(n, 8'h00);
        ena = 1'b1;
        scan(1, 4);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        scan(5, 5);
        wr_en = 1'b0;
        scan(6, 48);

        // Frame B: load back bank with 1<<n, request swap during column 2.
        for (int n = 0; n < 8; n++) push(n, 8'h00);
        wr_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            wr_addr = 3'(n);
            wr_data = 8'(1 << n);
            scan(n + 1, n + 1);
        end
        wr_en = 1'b0;
        scan(9, 13);
        swap_req = 1'b1;
        scan(14, 14);
        swap_req = 1'b0;
        chk("pending_set", 32'(swap_pending), 32'd1);
        scan(15, 48);
        chk("pending_held", 32'(swap_pending), 32'd1);
        chk("swap_done_early", 32'(swap_done), 32'd0);

        // Frame C: swapped, front shows 1<<n; write 0x5A to back addr 5.
        for (int n = 0; n < 8; n++) push(n, 8'(1 << n));
        scan(1, 1);
        chk("swap1_done", 32'(swap_done), 32'd1);
        chk("swap1_pending_clr", 32'(swap_pending), 32'd0);
        scan(2, 2);
        chk("swap1_done_pulse", 32'(swap_done), 32'd0);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h5A;
        scan(3, 3);
        wr_en = 1'b0;
        scan(4, 48);

        // Swap request and write on the exact swap edge.
        swap_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        push(0, 8'hFF);
        for (int n = 1; n < 5; n++) push(n, 8'h00);
        push(5, 8'h5A);
        scan(1, 1);
        swap_req = 1'b0; wr_en = 1'b0;
        chk("swap2_done", 32'(swap_done), 32'd1);
        chk("swap2_pending", 32'(swap_pending), 32'd0);

        // Frame D: new pending request, then drop ena during column 5 dwell.
        swap_req = 1'b1;
        scan(2, 2);
        swap_req = 1'b0;
        chk("pending_d", 32'(swap_pending), 32'd1);
        scan(3, 34);
        ena = 1'b0;
        step();
        chk("drop_drive_en", 32'(drive_en), 32'd0);
        chk("drop_col_sel", 32'(col_sel), 32'd0);
        chk("drop_row_hold", 32'(row_data), 32'h5A);
        chk("drop_pending", 32'(swap_pending), 32'd1);
        step();
        step();
        chk("idle_pending", 32'(swap_pending), 32'd1);
        chk("idle_no_swap", 32'(swap_done), 32'd0);

        // Frame E: restart at column 0, pending swap honoured at frame end.
        push(0, 8'hFF);
        for (int n = 1; n < 8; n++) push(n, (n == 5) ? 8'h5A : 8'h00);
        ena = 1'b1;
        scan(1, 48);
        chk("pending_e_end", 32'(swap_pending), 32'd1);

        // Frame F: reset mid-dwell with a swap pending.
        push(0, 8'h01);
        push(1, 8'h02);
        scan(1, 1);
        chk("swap3_done", 32'(swap_done), 32'd1);
        chk("swap3_pending", 32'(swap_pending), 32'd0);
        swap_req = 1'b1;
        scan(2, 2);
        swap_req = 1'b0;
        chk("pending_f", 32'(swap_pending), 32'd1);
        scan(3, 10);
        rst = 1'b1;
        ena = 1'b0;
        step();
        chk_reset_state("midrst");
        rst = 1'b0;

        // Frame G: banks cleared by reset.
        for (int n = 0; n < 8; n++) push(n, 8'h00);
        ena = 1'b1;
        scan(1, 48);
        ena = 1'b0;
        step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
